// File: rtl/layer_sequencer_if.sv
// Handshake/config bundle between the switch-enable logic, the layer sequencer
// and the scan controller.
interface layer_sequencer_if #(
  parameter int CH     = 8,
  parameter int CNT_W  = 16,
  parameter int LAYERS = 4,
  parameter int IDX_W  = 2
);
  logic                      start;
  logic                      abort;
  logic [CH-1:0]             switchEnLogic;
  logic [LAYERS*CH-1:0]      layerCfg;
  logic [LAYERS*CNT_W-1:0]   layerCnt;
  logic [LAYERS-1:0]         baseLayer;
  logic [IDX_W:0]            numLayers;
  logic                      busy;
  logic [IDX_W-1:0]          layerIdx;
  logic [CNT_W-1:0]          repeatCnt;
  logic                      layerLast;
  logic                      layerEnd;
  logic                      seqDone;

  modport master (
    output start, abort, switchEnLogic, layerCfg, layerCnt, baseLayer, numLayers,
    input  busy, layerIdx, repeatCnt, layerLast, layerEnd, seqDone
  );

  modport slave (
    input  start, abort, switchEnLogic, layerCfg, layerCnt, baseLayer, numLayers,
    output busy, layerIdx, repeatCnt, layerLast, layerEnd, seqDone
  );
endinterface

// File: rtl/layer_sequencer.sv
// Multi-layer repeat sequencer: counts qualified switch-enable events per layer
// using configuration latched at start, pulsing layer-end and sequence-done.
module layer_sequencer #(
  parameter int CH     = 8,
  parameter int CNT_W  = 16,
  parameter int LAYERS = 4,
  parameter int IDX_W  = 2
) (
  input  logic               io_clk,
  input  logic               io_rst,
  layer_sequencer_if.slave   io
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                   state_r, nextState_s;
  logic [IDX_W-1:0]         idx_r;
  logic [CNT_W-1:0]         repeat_r;
  logic [LAYERS*CH-1:0]     shadowCfg_r;
  logic [LAYERS*CNT_W-1:0]  shadowCnt_r;
  logic [LAYERS-1:0]        shadowBase_r;
  logic [IDX_W:0]           numLayers_r;
  logic                     layerEnd_r;
  logic                     seqDone_r;

  logic [CH-1:0]            curCfg_s;
  logic [CNT_W-1:0]         curCnt_s;
  logic                     curBase_s;
  logic                     trig_s;
  logic                     layerLast_s;
  logic                     finalLayer_s;
  logic [IDX_W:0]           clampNum_s;
  logic                     startAcc_s;
  logic                     abortAcc_s;
  logic                     advance_s;
  logic                     inc_s;

  // State register
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; abort beats a same-cycle trigger
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (io.start) nextState_s = RUN;
        else          nextState_s = IDLE;
      end
      RUN: begin
        if (io.abort)                                 nextState_s = IDLE;
        else if (trig_s && layerLast_s && finalLayer_s) nextState_s = IDLE;
        else                                          nextState_s = RUN;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Output and control decode from the registered state and shadow config
  always_comb begin
    curCfg_s  = shadowCfg_r[int'(idx_r)*CH +: CH];
    curCnt_s  = shadowCnt_r[int'(idx_r)*CNT_W +: CNT_W];
    curBase_s = shadowBase_r[idx_r];
    trig_s    = (state_r == RUN) && (|(io.switchEnLogic & curCfg_s));

    // n-1 is only formed when n is non-zero, so the compare never underflows
    if (curCnt_s == '0)  layerLast_s = 1'b1;
    else if (curBase_s)  layerLast_s = (repeat_r == (curCnt_s - CNT_W'(1)));
    else                 layerLast_s = (repeat_r == curCnt_s);

    finalLayer_s = ({1'b0, idx_r} == (numLayers_r - (IDX_W+1)'(1)));

    if (io.numLayers == '0)                       clampNum_s = (IDX_W+1)'(1);
    else if (io.numLayers > (IDX_W+1)'(LAYERS))   clampNum_s = (IDX_W+1)'(LAYERS);
    else                                          clampNum_s = io.numLayers;

    startAcc_s = (state_r == IDLE) && io.start;
    abortAcc_s = (state_r == RUN) && io.abort;
    advance_s  = (state_r == RUN) && !io.abort && trig_s && layerLast_s;
    inc_s      = (state_r == RUN) && !io.abort && trig_s && !layerLast_s;

    io.busy      = (state_r == RUN);
    io.layerIdx  = idx_r;
    io.repeatCnt = repeat_r;
    io.layerLast = layerLast_s;
    io.layerEnd  = layerEnd_r;
    io.seqDone   = seqDone_r;
  end

  // Datapath: shadow config, layer index, repeat counter and event pulses
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      idx_r        <= '0;
      repeat_r     <= '0;
      shadowCfg_r  <= '0;
      shadowCnt_r  <= '0;
      shadowBase_r <= '0;
      numLayers_r  <= '0;
      layerEnd_r   <= 1'b0;
      seqDone_r    <= 1'b0;
    end else begin
      layerEnd_r <= advance_s;
      seqDone_r  <= (advance_s && finalLayer_s) || abortAcc_s;
      if (startAcc_s) begin
        shadowCfg_r  <= io.layerCfg;
        shadowCnt_r  <= io.layerCnt;
        shadowBase_r <= io.baseLayer;
        numLayers_r  <= clampNum_s;
        idx_r        <= '0;
        repeat_r     <= '0;
      end else if (abortAcc_s) begin
        idx_r    <= '0;
        repeat_r <= '0;
      end else if (advance_s) begin
        repeat_r <= '0;
        if (finalLayer_s) idx_r <= '0;
        else              idx_r <= idx_r + IDX_W'(1);
      end else if (inc_s) begin
        repeat_r <= repeat_r + CNT_W'(1);
      end else begin
        repeat_r <= repeat_r;
      end
    end
  end

endmodule
